// File: rtl/read_iq.sv
// Drains a byte FIFO of interleaved little-endian I/Q samples and pushes quantized
// 32-bit I and Q words into paired sample FIFOs. Define IQ_SWAP_EN for Q-first streams.
module read_iq #(
  parameter int QUANT_BITS = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_dout,
  input  logic        in_empty,
  output logic        in_rd_en,
  output logic [31:0] i_out,
  output logic [31:0] q_out,
  output logic        i_wr_en,
  output logic        q_wr_en,
  input  logic        i_full,
  input  logic        q_full
);

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] i_reg_q, i_reg_d;
  logic [15:0] q_reg_q, q_reg_d;
  logic [31:0] i_ext, q_ext;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    i_reg_d    = i_reg_q;
    q_reg_d    = q_reg_q;
    in_rd_en   = 1'b0;
    i_wr_en    = 1'b0;
    q_wr_en    = 1'b0;
    i_out      = '0;
    q_out      = '0;
    i_ext      = {{16{i_reg_q[15]}}, i_reg_q};
    q_ext      = {{16{q_reg_q[15]}}, q_reg_q};

    if (!reset) begin
      case (state_q)
        S_READ: begin
          if (!in_empty) begin
            in_rd_en   = 1'b1;
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
`ifdef IQ_SWAP_EN
              2'd0:    q_reg_d[7:0]  = in_dout;
              2'd1:    q_reg_d[15:8] = in_dout;
              2'd2:    i_reg_d[7:0]  = in_dout;
              default: i_reg_d[15:8] = in_dout;
`else
              2'd0:    i_reg_d[7:0]  = in_dout;
              2'd1:    i_reg_d[15:8] = in_dout;
              2'd2:    q_reg_d[7:0]  = in_dout;
              default: q_reg_d[15:8] = in_dout;
`endif
            endcase
            if (byte_cnt_q == 2'd3) state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          i_out = i_ext << QUANT_BITS;
          q_out = q_ext << QUANT_BITS;
          // Both FIFOs must have room so I and Q are never written separately.
          if (!i_full && !q_full) begin
            i_wr_en = 1'b1;
            q_wr_en = 1'b1;
            state_d = S_READ;
          end
        end
        default: state_d = S_READ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_READ;
      byte_cnt_q <= '0;
      i_reg_q    <= '0;
      q_reg_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      i_reg_q    <= i_reg_d;
      q_reg_q    <= q_reg_d;
    end
  end

endmodule

// File: tb/tb_read_iq.sv
// Scoreboard bench for read_iq: a byte-queue model of the input FIFO feeds the DUT,
// expected I/Q words are queued at stimulus time and popped by a write monitor.
module tb_read_iq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_dout = 8'hEE;
  logic        in_empty = 1'b1;
  logic        in_rd_en;
  logic [31:0] i_out, q_out;
  logic        i_wr_en, q_wr_en;
  logic        i_full = 1'b0;
  logic        q_full = 1'b0;

  always #5 clock = ~clock;

  read_iq #(.QUANT_BITS(10)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_dout  (in_dout),
    .in_empty (in_empty),
    .in_rd_en (in_rd_en),
    .i_out    (i_out),
    .q_out    (q_out),
    .i_wr_en  (i_wr_en),
    .q_wr_en  (q_wr_en),
    .i_full   (i_full),
    .q_full   (q_full)
  );

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;

  logic [7:0]  bq[$];
  logic [63:0] exp_q[$];
  logic        reset_s = 1'b1;
  logic        i_full_s = 1'b0;
  logic        q_full_s = 1'b0;
  logic        rd_now, wr_now;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Inputs change only at negedge; the sampled rd/wr are what the next posedge acts on.
  task automatic cycle();
    @(negedge clock);
    reset    = reset_s;
    i_full   = i_full_s;
    q_full   = q_full_s;
    in_empty = (bq.size() == 0);
    in_dout  = in_empty ? 8'hEE : bq[0];
    #1;
    rd_now = in_rd_en;
    wr_now = i_wr_en | q_wr_en;
    if (in_rd_en && bq.size() > 0) void'(bq.pop_front());
  endtask

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1);
    bq.push_back(b0);
    bq.push_back(b1);
  endtask

  task automatic push_exp(input logic [31:0] ei, input logic [31:0] eq);
`ifdef IQ_SWAP_EN
    exp_q.push_back({eq, ei});
`else
    exp_q.push_back({ei, eq});
`endif
  endtask

  always @(negedge clock) begin
    logic [63:0] e;
    #2;
    if (i_wr_en || q_wr_en) begin
      wr_cnt++;
      chk("wr_en_pair", {31'd0, q_wr_en}, {31'd0, i_wr_en});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write i_out=%h q_out=%h exp=none", i_out, q_out);
      end else begin
        e = exp_q.pop_front();
        chk("i_out", i_out, e[63:32]);
        chk("q_out", q_out, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without completion");
    $fatal(1);
  end

  initial begin
    logic [5:0] rdh, wrh;
    int         n;
    logic       act;

    // Reset with bytes waiting: nothing may be popped or written.
    push_bytes(8'h34, 8'h12);
    push_bytes(8'hCD, 8'hAB);
    push_exp(32'h0048D000, 32'hFEAF3400);
    cycle();
    chk("reset_rd_en", {31'd0, rd_now}, 32'd0);
    cycle();
    chk("reset_wr_en", {31'd0, wr_now}, 32'd0);
    chk("reset_i_out", i_out, 32'd0);

    // Basic sample: four pops then one write.
    reset_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      rdh[i] = rd_now;
      wrh[i] = wr_now;
    end
    chk("basic_rd_pattern", {26'd0, rdh}, 32'h0000000F);
    chk("basic_wr_pattern", {26'd0, wrh}, 32'h00000010);

    // Q FIFO full: hold in write state with the next sample already waiting.
    q_full_s = 1'b1;
    push_bytes(8'hFF, 8'hFF);
    push_bytes(8'h01, 8'h00);
    push_exp(32'hFFFFFC00, 32'h00000400);
    push_bytes(8'h00, 8'h80);
    push_bytes(8'hFF, 8'h7F);
    push_exp(32'hFE000000, 32'h01FFFC00);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n += int'(rd_now);
      if (wr_now) n += 100;
    end
    chk("full_pops", n, 32'd4);
    act = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      act = act | rd_now | wr_now;
    end
    chk("full_stall_idle", {31'd0, act}, 32'd0);
    q_full_s = 1'b0;
    cycle();
    chk("full_release_wr", {31'd0, wr_now}, 32'd1);
    chk("full_release_rd", {31'd0, rd_now}, 32'd0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n += int'(rd_now);
    end
    chk("extreme_pops", n, 32'd4);
    cycle();
    chk("extreme_wr", {31'd0, wr_now}, 32'd1);

    // Input empty after two bytes; the sample must resume intact.
    push_bytes(8'h78, 8'h56);
    push_exp(32'h0159E000, 32'h010C8400);
    n = 0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n += int'(rd_now);
    end
    chk("empty_first_pops", n, 32'd2);
    act = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      act = act | rd_now | wr_now;
    end
    chk("empty_stall_idle", {31'd0, act}, 32'd0);
    push_bytes(8'h21, 8'h43);
    n = 0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n += int'(rd_now);
    end
    chk("empty_resume_pops", n, 32'd2);
    cycle();
    chk("empty_resume_wr", {31'd0, wr_now}, 32'd1);

    // Reset after three bytes discards the partial sample.
    push_bytes(8'hAA, 8'hBB);
    bq.push_back(8'hCC);
    for (int i = 0; i < 3; i++) cycle();
    reset_s = 1'b1;
    cycle();
    chk("midreset_wr", {31'd0, wr_now}, 32'd0);
    reset_s = 1'b0;
    push_bytes(8'h02, 8'h00);
    push_bytes(8'h03, 8'h00);
    push_exp(32'h00000800, 32'h00000C00);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n += int'(rd_now);
    end
    chk("postreset_pops", n, 32'd4);
    cycle();
    chk("postreset_wr", {31'd0, wr_now}, 32'd1);

    for (int i = 0; i < 4; i++) cycle();
    chk("total_writes", wr_cnt, 32'd5);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
